// File: rtl/qsys_pkg.sv
// rtl/qsys_pkg.sv - shared FSM state type and byte-lane geometry for the host bridge
package qsys_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    localparam int LANES  = 4;
    localparam int LANE_W = 8;

endpackage

// File: rtl/qsys_host_bridge_if.sv
// rtl/qsys_host_bridge_if.sv - device-side and Avalon-side signal bundle of the host bridge
interface qsys_host_bridge_if #(
    parameter int address_size = 8
);
    logic [address_size-1:0] dev_address;
    logic                    dev_write;
    logic                    dev_read;
    logic [7:0]              dev_writedata;
    logic [7:0]              dev_readdata;
    logic                    dev_waitrequest;
    logic                    dev_error;

    logic [address_size-1:0] avm_m0_address;
    logic [31:0]             avm_m0_writedata;
    logic [3:0]              avm_m0_byteenable;
    logic                    avm_m0_write;
    logic                    avm_m0_read;
    logic [31:0]             avm_m0_readdata;
    logic                    avm_m0_waitrequest;

    // master: the bridge's view; slave: the surrounding device initiator and Avalon slave
    modport master (
        input  dev_address, dev_write, dev_read, dev_writedata,
        output dev_readdata, dev_waitrequest, dev_error,
        output avm_m0_address, avm_m0_writedata, avm_m0_byteenable, avm_m0_write, avm_m0_read,
        input  avm_m0_readdata, avm_m0_waitrequest
    );

    modport slave (
        output dev_address, dev_write, dev_read, dev_writedata,
        input  dev_readdata, dev_waitrequest, dev_error,
        input  avm_m0_address, avm_m0_writedata, avm_m0_byteenable, avm_m0_write, avm_m0_read,
        output avm_m0_readdata, avm_m0_waitrequest
    );

endinterface

// File: rtl/qsys_byte_lane.sv
// rtl/qsys_byte_lane.sv - byte-lane steering between an 8-bit device and a 32-bit Avalon bus
module qsys_byte_lane
    import qsys_pkg::*;
(
    input  logic [1:0]              wr_lane,
    input  logic [LANE_W-1:0]       wbyte,
    input  logic [1:0]              rd_lane,
    input  logic [LANES*LANE_W-1:0] rdata,
    output logic [LANES-1:0]        be,
    output logic [LANES*LANE_W-1:0] wdata,
    output logic [LANE_W-1:0]       rbyte
);

    assign be    = 4'b0001 << wr_lane;
    assign wdata = {LANES{wbyte}};
    assign rbyte = rdata[rd_lane*LANE_W +: LANE_W];

endmodule

// File: rtl/qsys_host_bridge.sv
// rtl/qsys_host_bridge.sv - 8-bit device initiator to 32-bit Avalon-MM master bridge with wait timeout
module qsys_host_bridge
    import qsys_pkg::*;
#(
    parameter int address_size = 8,
    parameter int TIMEOUT      = 255
) (
    input  logic                    csi_MCLK_clk,
    input  logic                    rsi_MRST_reset_n,
    input  logic [address_size-1:0] dev_address,
    input  logic                    dev_write,
    input  logic                    dev_read,
    input  logic [7:0]              dev_writedata,
    output logic [7:0]              dev_readdata,
    output logic                    dev_waitrequest,
    output logic                    dev_error,
    output logic [address_size-1:0] avm_m0_address,
    output logic [31:0]             avm_m0_writedata,
    output logic [3:0]              avm_m0_byteenable,
    output logic                    avm_m0_write,
    output logic                    avm_m0_read,
    input  logic [31:0]             avm_m0_readdata,
    input  logic                    avm_m0_waitrequest
);

    localparam logic [31:0] TIMEOUT_W = 32'(TIMEOUT);

    state_t      state;
    logic        op_wr_q;
    logic [1:0]  lane_q;
    logic [31:0] tmo_cnt;
    logic [31:0] tmo_nxt;
    logic [3:0]  be_c;
    logic [31:0] wd_c;
    logic [7:0]  rbyte_c;

    // Write-side lanes decode straight from the device inputs at accept; read-back uses the latched lane.
    qsys_byte_lane u_lane (
        .wr_lane (dev_address[1:0]),
        .wbyte   (dev_writedata),
        .rd_lane (lane_q),
        .rdata   (avm_m0_readdata),
        .be      (be_c),
        .wdata   (wd_c),
        .rbyte   (rbyte_c)
    );

    assign tmo_nxt         = tmo_cnt + 32'd1;
    assign dev_waitrequest = (dev_read | dev_write) & (state != ST_DONE);

    always_ff @(posedge csi_MCLK_clk or negedge rsi_MRST_reset_n) begin
        if (!rsi_MRST_reset_n) begin
            state             <= ST_IDLE;
            op_wr_q           <= 1'b0;
            lane_q            <= 2'b00;
            tmo_cnt           <= 32'd0;
            dev_readdata      <= 8'h00;
            dev_error         <= 1'b0;
            avm_m0_address    <= '0;
            avm_m0_writedata  <= 32'h0;
            avm_m0_byteenable <= 4'h0;
            avm_m0_write      <= 1'b0;
            avm_m0_read       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (dev_write || dev_read) begin
                        op_wr_q           <= dev_write;
                        lane_q            <= dev_address[1:0];
                        avm_m0_address    <= {dev_address[address_size-1:2], 2'b00};
                        avm_m0_writedata  <= wd_c;
                        avm_m0_byteenable <= be_c;
                        avm_m0_write      <= dev_write;
                        avm_m0_read       <= ~dev_write;
                        dev_error         <= 1'b0;
                        tmo_cnt           <= 32'd0;
                        state             <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (!avm_m0_waitrequest) begin
                        avm_m0_write <= 1'b0;
                        avm_m0_read  <= 1'b0;
                        if (!op_wr_q) dev_readdata <= rbyte_c;
                        state        <= ST_DONE;
                    end else begin
                        tmo_cnt <= tmo_nxt;
                        // Give up in the cycle the stall count reaches TIMEOUT.
                        if (TIMEOUT != 0 && tmo_nxt == TIMEOUT_W) begin
                            avm_m0_write <= 1'b0;
                            avm_m0_read  <= 1'b0;
                            if (!op_wr_q) dev_readdata <= 8'hFF;
                            dev_error    <= 1'b1;
                            state        <= ST_DONE;
                        end
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_qsys_host_bridge.sv
// tb/tb_qsys_host_bridge.sv - randomized self-checking bench for qsys_host_bridge against a transaction model
module tb_qsys_host_bridge;

    localparam int AW  = 8;
    localparam int TMO = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    qsys_host_bridge_if #(.address_size(AW)) bus ();

    qsys_host_bridge #(.address_size(AW), .TIMEOUT(TMO)) dut (
        .csi_MCLK_clk       (clk),
        .rsi_MRST_reset_n   (rst_n),
        .dev_address        (bus.dev_address),
        .dev_write          (bus.dev_write),
        .dev_read           (bus.dev_read),
        .dev_writedata      (bus.dev_writedata),
        .dev_readdata       (bus.dev_readdata),
        .dev_waitrequest    (bus.dev_waitrequest),
        .dev_error          (bus.dev_error),
        .avm_m0_address     (bus.avm_m0_address),
        .avm_m0_writedata   (bus.avm_m0_writedata),
        .avm_m0_byteenable  (bus.avm_m0_byteenable),
        .avm_m0_write       (bus.avm_m0_write),
        .avm_m0_read        (bus.avm_m0_read),
        .avm_m0_readdata    (bus.avm_m0_readdata),
        .avm_m0_waitrequest (bus.avm_m0_waitrequest)
    );

    int checks = 0;
    int errors = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %h required %h at %0t", name, act, exp, $time);
        end
    endfunction

    // Expected outputs for the current cycle and the model's persistent state
    bit          check_en = 1'b0;
    bit          e_wr, e_rd, e_dwait, e_err, chk_wd;
    logic [7:0]  e_addr, e_rdata;
    logic [3:0]  e_be;
    logic [31:0] e_wd;
    logic [7:0]  m_rdata = 8'h00;
    bit          m_err   = 1'b0;

    always @(negedge clk) begin
        if (check_en) begin
            chk("avm_write",       32'(bus.avm_m0_write),    32'(e_wr));
            chk("avm_read",        32'(bus.avm_m0_read),     32'(e_rd));
            chk("dev_waitrequest", 32'(bus.dev_waitrequest), 32'(e_dwait));
            chk("dev_error",       32'(bus.dev_error),       32'(e_err));
            chk("dev_readdata",    32'(bus.dev_readdata),    32'(e_rdata));
            if (e_wr || e_rd) begin
                chk("avm_address",    32'(bus.avm_m0_address),    32'(e_addr));
                chk("avm_byteenable", 32'(bus.avm_m0_byteenable), 32'(e_be));
                if (chk_wd) chk("avm_writedata", bus.avm_m0_writedata, e_wd);
            end
        end
    end

    // Observation of completed bus activity for the literal checks
    int          cyc = 0;
    bit          prev_cmd = 1'b0;
    int          cmd_len = 0;
    logic [7:0]  snap_addr, snap_rd;
    logic [3:0]  snap_be;
    logic [31:0] snap_wd;
    bit          snap_w, snap_r, snap_err;
    int          starts[$];
    logic [3:0]  bes[$];

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if ((bus.avm_m0_write || bus.avm_m0_read) && !prev_cmd) begin
            snap_addr = bus.avm_m0_address;
            snap_be   = bus.avm_m0_byteenable;
            snap_wd   = bus.avm_m0_writedata;
            snap_w    = bus.avm_m0_write;
            snap_r    = bus.avm_m0_read;
            cmd_len   = 0;
            starts.push_back(cyc);
            bes.push_back(bus.avm_m0_byteenable);
        end
        if (bus.avm_m0_write || bus.avm_m0_read) cmd_len++;
        prev_cmd = bus.avm_m0_write || bus.avm_m0_read;
        if (rst_n && !bus.dev_waitrequest && (bus.dev_read || bus.dev_write)) begin
            snap_rd  = bus.dev_readdata;
            snap_err = bus.dev_error;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_quiet(bit dwait);
        e_wr = 1'b0; e_rd = 1'b0; chk_wd = 1'b0;
        e_dwait = dwait; e_err = m_err; e_rdata = m_rdata;
    endtask

    task automatic idle_cycle();
        step();
        bus.dev_write = 1'b0;
        bus.dev_read  = 1'b0;
        bus.avm_m0_waitrequest = 1'($urandom);
        bus.avm_m0_readdata    = 32'($urandom);
        set_quiet(1'b0);
    endtask

    // One device transaction: IDLE accept, ACCESS for the slave's stall pattern, one DONE cycle.
    task automatic txn(bit wr, logic [7:0] addr, logic [7:0] data, int waits,
                       logic [31:0] rdata, bit both);
        bit tmo;
        int n;
        tmo = (waits >= TMO);
        n   = tmo ? TMO : waits + 1;
        step();
        bus.dev_write     = wr;
        bus.dev_read      = !wr || both;
        bus.dev_address   = addr;
        bus.dev_writedata = data;
        bus.avm_m0_waitrequest = 1'($urandom);
        bus.avm_m0_readdata    = 32'($urandom);
        set_quiet(1'b1);
        for (int i = 1; i <= n; i++) begin
            step();
            bus.dev_address   = 8'($urandom);
            bus.dev_writedata = 8'($urandom);
            bus.avm_m0_waitrequest = (i <= waits);
            bus.avm_m0_readdata    = (i <= waits) ? 32'($urandom) : rdata;
            e_wr = wr; e_rd = !wr; chk_wd = wr;
            e_addr = {addr[7:2], 2'b00};
            e_be   = 4'b0001 << addr[1:0];
            e_wd   = {4{data}};
            e_dwait = 1'b1; e_err = 1'b0; e_rdata = m_rdata;
        end
        step();
        if (!wr) m_rdata = tmo ? 8'hFF : 8'(rdata >> (8 * addr[1:0]));
        m_err = tmo;
        bus.avm_m0_waitrequest = 1'($urandom);
        bus.avm_m0_readdata    = 32'($urandom);
        set_quiet(1'b0);
    endtask

    initial begin
        bus.dev_write = 1'b0; bus.dev_read = 1'b0;
        bus.dev_address = 8'h00; bus.dev_writedata = 8'h00;
        bus.avm_m0_waitrequest = 1'b0; bus.avm_m0_readdata = 32'h0;
        set_quiet(1'b0);
        e_addr = 8'h00; e_be = 4'h0; e_wd = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        check_en = 1'b1;
        @(negedge clk);
        #1;
        rst_n = 1'b1;

        txn(1'b1, 8'h13, 8'hA5, 0, 32'h0, 1'b0);
        idle_cycle();
        chk("w13_address", 32'(snap_addr), 32'h10);
        chk("w13_be",      32'(snap_be),   32'h8);
        chk("w13_wd",      snap_wd,        32'hA5A5A5A5);
        chk("w13_len",     32'(cmd_len),   32'd1);

        txn(1'b0, 8'h06, 8'h00, 3, 32'h44332211, 1'b0);
        idle_cycle();
        chk("r06_len",  32'(cmd_len), 32'd4);
        chk("r06_be",   32'(snap_be), 32'h4);
        chk("r06_data", 32'(snap_rd), 32'h33);

        txn(1'b0, 8'h01, 8'h00, 50, 32'h12345678, 1'b0);
        idle_cycle();
        chk("tmo_len",  32'(cmd_len),  32'd4);
        chk("tmo_data", 32'(snap_rd),  32'hFF);
        chk("tmo_err",  32'(snap_err), 32'd1);
        txn(1'b1, 8'h02, 8'h5A, 0, 32'h0, 1'b0);
        idle_cycle();
        chk("tmo_err_clear", 32'(snap_err), 32'd0);

        txn(1'b1, 8'h00, 8'h3C, 0, 32'h0, 1'b1);
        idle_cycle();
        chk("both_write", 32'(snap_w),  32'd1);
        chk("both_read",  32'(snap_r),  32'd0);
        chk("both_be",    32'(snap_be), 32'h1);

        starts.delete();
        bes.delete();
        txn(1'b1, 8'h21, 8'h11, 0, 32'h0, 1'b0);
        txn(1'b1, 8'h42, 8'h22, 0, 32'h0, 1'b0);
        idle_cycle();
        chk("b2b_count", 32'(starts.size()), 32'd2);
        if (starts.size() == 2) begin
            chk("b2b_spacing", 32'(starts[1] - starts[0]), 32'd3);
            chk("b2b_be0",     32'(bes[0]), 32'h2);
            chk("b2b_be1",     32'(bes[1]), 32'h4);
        end

        // Reset in the middle of a stalled read
        step();
        bus.dev_read = 1'b1; bus.dev_address = 8'h09;
        bus.avm_m0_waitrequest = 1'b1;
        set_quiet(1'b1);
        repeat (2) begin
            step();
            e_rd = 1'b1; e_addr = 8'h08; e_be = 4'h2;
            e_dwait = 1'b1; e_err = 1'b0;
        end
        #2;
        rst_n = 1'b0;
        bus.dev_read = 1'b0;
        #1;
        chk("rst_read",     32'(bus.avm_m0_read),       32'd0);
        chk("rst_write",    32'(bus.avm_m0_write),      32'd0);
        chk("rst_address",  32'(bus.avm_m0_address),    32'h0);
        chk("rst_be",       32'(bus.avm_m0_byteenable), 32'h0);
        chk("rst_wd",       bus.avm_m0_writedata,       32'h0);
        chk("rst_readdata", 32'(bus.dev_readdata),      32'h0);
        chk("rst_error",    32'(bus.dev_error),         32'd0);
        m_rdata = 8'h00;
        m_err   = 1'b0;
        set_quiet(1'b0);
        step();
        rst_n = 1'b1;
        set_quiet(1'b0);

        repeat (80) begin
            bit wr, both;
            wr   = 1'($urandom);
            both = wr && ($urandom_range(0, 3) == 0);
            txn(wr, 8'($urandom), 8'($urandom), int'($urandom_range(0, 6)), 32'($urandom), both);
            if ($urandom_range(0, 1) == 0) idle_cycle();
        end
        idle_cycle();
        idle_cycle();
        check_en = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
